sop_eval_pipe: RTL and testbench
================================

Name: sop_eval_pipe

Overview:
- Programmable, pipelined sum-of-products evaluator; the parametrised successor to the fixed AND-OR gate netlists used in the ezpz logic tests.
- N_TERM product terms are evaluated over N_IN inputs. Each term is defined by a positive-literal mask and a negative-literal mask.
- Each of N_OUT outputs ORs a configurable subset of the terms.
- Provides golden/stimulus logic with registered, back-pressurable outputs for the synthesis and equivalence benches.

Parameters:
- N_IN, 10, number of primary inputs per evaluation vector
- N_TERM, 8, number of product terms
- N_OUT, 1, number of OR outputs
- CFG_W, max(N_IN,N_TERM), width of the config data bus (derived; do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  input accepted when in_valid&&in_ready
- in_vec  in  N_IN  input literals
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_vec  out  N_OUT  SOP results
- cfg_we  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_we&&cfg_ready
- cfg_kind  in  2  0=pos mask, 1=neg mask, 2=or mask, 3=reserved (ignored)
- cfg_addr  in  8  term index (kind 0/1) or output index (kind 2)
- cfg_data  in  CFG_W  mask value, LSB-aligned; unused upper bits ignored

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset state:
  - all pos, neg and or masks = 0
  - both pipeline valid bits = 0
  - out_vec = 0, out_valid = 0
  - in_ready = 1, cfg_ready = 1 (values in the first cycle after reset)
  - Reset mid-operation discards in-flight data with no output handshake.
- Term evaluation: term[t] = AND over i of ((!pos[t][i] | in_vec[i]) & (!neg[t][i] | !in_vec[i])).
  - pos = neg = 0 gives a constant-1 term.
  - pos[i] & neg[i] both set gives a constant-0 term.
- Output evaluation: out[o] = OR over t of (or_mask[o][t] & term_reg[t]). An all-zero or mask gives 0.
- Pipeline:
  - S1 registers the N_TERM term vector; S2 registers out_vec.
  - Latency is exactly 2 cycles from input handshake to out_valid with no back-pressure.
  - Throughput is 1 vector per cycle.
- Stall rule:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1 & !cfg_we
  - out_vec and out_valid hold stable while out_valid & !out_ready.
- Config:
  - cfg_ready = !s1_valid & !s2_valid & !in_valid (pipeline fully drained and no input pending).
  - An accepted write updates the mask at the next edge. It is visible to the first vector accepted afterwards.
  - cfg_we has priority over in_valid in the same cycle: in_ready = 0 while cfg_we is high.
  - Out-of-range cfg_addr (>= N_TERM for kinds 0/1, >= N_OUT for kind 2) is accepted and dropped.
  - A cfg_kind = 3 write is accepted and dropped.
- Simultaneous in_valid and out_ready on a full pipeline: both stages advance, with no bubble.

Optional Feature:
- Macro: SOP_EVAL_TERM_HIT_EN.
- Defined:
  - Extra output port term_hit [N_TERM] carries the S1 term vector registered alongside out_vec.
  - It is valid and held under the same rules as out_vec.
  - Reset value is 0.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package sop_eval_pkg:
  - cfg_kind enum (CFG_POS, CFG_NEG, CFG_OR, CFG_RSVD)
  - function computing CFG_W
  - localparam LATENCY = 2
- Sub-module sop_term: a single combinational term evaluator (pos, neg, vec -> hit), instantiated N_TERM times via generate.
- Mask storage and pipeline stay in the top module.

Test Plan:
- Reset, then in_vec = 10'h3FF with in_valid -> out_valid after 2 cycles, out_vec = 0 (all or masks 0).
- Program term0 pos = 10'b0000000011 (a&b), or0 = 8'h01; send 10'h003 -> out = 1; send 10'h001 -> out = 0; each 2 cycles after its handshake.
- Program term1 pos = 10'h001, neg = 10'h001 (contradiction), or0 = 8'h02; send any vector -> out = 0. Program term2 with pos = neg = 0 and or0 = 8'h04 -> out = 1 for every vector.
- Stream 4 back-to-back vectors with out_ready held low for 3 cycles -> in_ready falls after 2 accepted. out_vec stays stable. All 4 results emerge in order, with no loss or duplication.
- Assert cfg_we while s1_valid = 1 -> cfg_ready = 0 until drained; the write lands afterwards. A later vector uses the new mask, an earlier one the old mask.
- Assert rst_n = 0 with both stages valid -> next cycle out_valid = 0, all masks 0. With SOP_EVAL_TERM_HIT_EN defined, term_hit = 0 at that point.

Source files
------------

// File: rtl/sop_eval_pkg.sv
// sop_eval_pkg: shared config-kind encoding, bus-width helper and pipeline latency
package sop_eval_pkg;
    typedef enum logic [1:0] {CFG_POS, CFG_NEG, CFG_OR, CFG_RSVD} cfg_kind_e;
    localparam int LATENCY = 2;
    function automatic int cfg_width(input int n_in, input int n_term);
        return n_in > n_term ? n_in : n_term;
    endfunction
endpackage

// File: rtl/sop_eval_pipe_term.sv
// sop_term: one product term, true when every required literal matches the input vector
module sop_term #(
    parameter int N_IN = 10
) (
    input  logic [N_IN-1:0] pos,
    input  logic [N_IN-1:0] neg,
    input  logic [N_IN-1:0] vec,
    output logic            hit
);
    assign hit = &((~pos | vec) & (~neg | ~vec));
endmodule

// File: rtl/sop_eval_pipe.sv
// sop_eval_pipe: programmable two-stage sum-of-products evaluator; SOP_EVAL_TERM_HIT_EN adds a term_hit output
module sop_eval_pipe
    import sop_eval_pkg::*;
#(
    parameter int N_IN   = 10,
    parameter int N_TERM = 8,
    parameter int N_OUT  = 1,
    parameter int CFG_W  = cfg_width(N_IN, N_TERM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_vec,
`ifdef SOP_EVAL_TERM_HIT_EN
    output logic [N_TERM-1:0] term_hit,
`endif
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_kind,
    input  logic [7:0]        cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data
);
    logic [N_TERM-1:0][N_IN-1:0] pos_q, pos_d, neg_q, neg_d;
    logic [N_OUT-1:0][N_TERM-1:0] or_q, or_d;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [N_TERM-1:0] term_q, term_d, hit;
    logic [N_OUT-1:0] out_q, out_d;
    logic adv1, adv2, cfg_acc;
`ifdef SOP_EVAL_TERM_HIT_EN
    logic [N_TERM-1:0] term_hit_q, term_hit_d;
    assign term_hit = term_hit_q;
`endif

    for (genvar t = 0; t < N_TERM; t++) begin : g_term
        sop_term #(.N_IN(N_IN)) u_term (.pos(pos_q[t]), .neg(neg_q[t]), .vec(in_vec), .hit(hit[t]));
    end

    always_comb begin
        adv2       = !s2_valid_q || out_ready;
        adv1       = !s1_valid_q || adv2;
        in_ready   = adv1 && !cfg_we;
        cfg_ready  = !s1_valid_q && !s2_valid_q && !in_valid;
        cfg_acc    = cfg_we && cfg_ready;
        for (int t = 0; t < N_TERM; t++) begin
            pos_d[t] = (cfg_acc && cfg_kind == CFG_POS && int'(cfg_addr) == t) ? cfg_data[N_IN-1:0] : pos_q[t];
            neg_d[t] = (cfg_acc && cfg_kind == CFG_NEG && int'(cfg_addr) == t) ? cfg_data[N_IN-1:0] : neg_q[t];
        end
        for (int o = 0; o < N_OUT; o++) begin
            or_d[o]  = (cfg_acc && cfg_kind == CFG_OR && int'(cfg_addr) == o) ? cfg_data[N_TERM-1:0] : or_q[o];
            out_d[o] = adv2 ? |(or_q[o] & term_q) : out_q[o];
        end
        s1_valid_d = adv1 ? in_valid && in_ready : s1_valid_q;
        term_d     = adv1 ? hit : term_q;
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
`ifdef SOP_EVAL_TERM_HIT_EN
        term_hit_d = adv2 ? term_q : term_hit_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q      <= '0;
            neg_q      <= '0;
            or_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            term_q     <= '0;
            out_q      <= '0;
`ifdef SOP_EVAL_TERM_HIT_EN
            term_hit_q <= '0;
`endif
        end else begin
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            or_q       <= or_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            term_q     <= term_d;
            out_q      <= out_d;
`ifdef SOP_EVAL_TERM_HIT_EN
            term_hit_q <= term_hit_d;
`endif
        end
    end

    assign out_vec   = out_q;
    assign out_valid = s2_valid_q;
endmodule

// File: tb/tb_sop_eval_pipe.sv
// tb_sop_eval_pipe: directed self-checking bench for sop_eval_pipe
module tb_sop_eval_pipe;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready, cfg_we;
    logic [9:0] in_vec, cfg_data;
    logic [1:0] cfg_kind;
    logic [7:0] cfg_addr;
    logic       in_ready, out_valid, cfg_ready;
    logic [0:0] out_vec;
`ifdef SOP_EVAL_TERM_HIT_EN
    logic [7:0] term_hit;
`endif
    int n_checks = 0, n_errors = 0;
    logic [9:0] sv [4] = '{10'h003, 10'h001, 10'h3FF, 10'h002};
    logic       ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    sop_eval_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
`ifdef SOP_EVAL_TERM_HIT_EN
        .term_hit(term_hit),
`endif
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_kind(cfg_kind),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] k, input logic [7:0] a, input logic [9:0] d);
        cfg_we = 1'b1; cfg_kind = k; cfg_addr = a; cfg_data = d;
        #1;
        check("cfg_ready", cfg_ready, 1);
        check("cfg_prio_in_ready", in_ready, 0);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [9:0] v, input logic e);
        in_valid = 1'b1; in_vec = v;
        step();
        in_valid = 1'b0;
        step();
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_vec, e);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, rcv, cyc, n;
        logic hs_in, seen;
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_kind = '0; cfg_addr = '0; cfg_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        run_vec("zero_or", 10'h3FF, 1'b0);

        cfg_wr(2'd0, 8'd0, 10'h003);
        cfg_wr(2'd2, 8'd0, 10'h001);
        run_vec("ab_003", 10'h003, 1'b1);
        run_vec("ab_001", 10'h001, 1'b0);

        cfg_wr(2'd0, 8'd1, 10'h001);
        cfg_wr(2'd1, 8'd1, 10'h001);
        cfg_wr(2'd2, 8'd0, 10'h002);
        run_vec("contra_3ff", 10'h3FF, 1'b0);
        run_vec("contra_001", 10'h001, 1'b0);

        cfg_wr(2'd2, 8'd0, 10'h004);
        run_vec("const1_000", 10'h000, 1'b1);
        run_vec("const1_2aa", 10'h2AA, 1'b1);
        run_vec("const1_3ff", 10'h3FF, 1'b1);

        cfg_wr(2'd2, 8'd1, 10'h000);
        cfg_wr(2'd3, 8'd0, 10'h000);
        run_vec("drop_or_rsvd", 10'h155, 1'b1);
        cfg_wr(2'd2, 8'd0, 10'h001);
        cfg_wr(2'd0, 8'd8, 10'h000);
        run_vec("drop_term_001", 10'h001, 1'b0);
        run_vec("drop_term_003", 10'h003, 1'b1);

        out_ready = 1'b0; in_valid = 1'b1; in_vec = sv[0];
        #1;
        check("bp_rdy0", in_ready, 1);
        step();
        in_vec = sv[1];
        check("bp_rdy1", in_ready, 1);
        step();
        in_vec = sv[2];
        check("bp_rdy2", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_vec", out_vec, ev[0]);
            check("bp_hold_rdy", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        sent = 2; rcv = 0; cyc = 0;
        while (cyc < 20 && rcv < 4) begin
            hs_in = in_valid && in_ready;
            if (out_valid) begin
                check("bp_order", out_vec, ev[rcv]);
                rcv++;
            end
            step();
            cyc++;
            if (hs_in) sent++;
            in_valid = sent < 4;
            if (sent < 4) in_vec = sv[sent];
            #1;
        end
        check("bp_rcv", rcv, 4);
        check("bp_sent", sent, 4);
        check("bp_no_bubble", cyc, 4);
        check("bp_drained", out_valid, 0);

        in_valid = 1'b1; cfg_we = 1'b1; cfg_kind = 2'd2; cfg_addr = 8'd0; cfg_data = 10'h002;
        #1;
        check("cfg_blk_in_valid", cfg_ready, 0);
        cfg_we = 1'b0; in_vec = 10'h003;
        step();
        in_valid = 1'b0; cfg_we = 1'b1;
        #1;
        check("cfg_busy_ready", cfg_ready, 0);
        check("cfg_busy_in_ready", in_ready, 0);
        n = 0; seen = 1'b0;
        while (!cfg_ready && n < 10) begin
            if (out_valid) begin
                check("cfg_old_mask", out_vec, 1);
                seen = 1'b1;
            end
            step();
            n++;
        end
        check("cfg_old_seen", seen, 1);
        check("cfg_drained_ready", cfg_ready, 1);
        step();
        cfg_we = 1'b0;
        run_vec("cfg_new_mask", 10'h003, 1'b0);

        cfg_wr(2'd2, 8'd0, 10'h004);
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 10'h000;
        step();
        step();
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        check("mid_full_vec", out_vec, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_vec", out_vec, 0);
        check("mid_rst_in_ready", in_ready, 1);
`ifdef SOP_EVAL_TERM_HIT_EN
        check("mid_rst_term_hit", term_hit, 0);
`endif
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_cfg_ready", cfg_ready, 1);
        run_vec("post_rst_masks", 10'h000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
